pc_hazard_sequencer: RTL and testbench

Sequences the program counter and the IF/ID and ID/EX pipeline registers of the hazard-controlled 5-stage RISC-V core. It combines load-use hazard detection, EX-stage taken-branch redirection with a parameterised multi-cycle squash, debug halt/resume, and a post-reset restart into one FSM. It drives the PC register's PC_In and PCWrite, plus the IF/ID write, IF/ID flush and ID/EX bubble controls. It also keeps saturating stall and flush counters.

---
 rtl/pc_hazard_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_hazard_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_hazard_sequencer.sv
// rtl/pc_hazard_sequencer.sv - PC and IF/ID, ID/EX pipeline sequencing FSM with hazard, redirect and halt control
module pc_hazard_sequencer #(
  parameter int PC_W         = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc_cur,
  input  logic              id_ex_mem_read,
  input  logic [4:0]        id_ex_rd,
  input  logic [4:0]        if_id_rs1,
  input  logic [4:0]        if_id_rs2,
  input  logic              branch_taken_ex,
  input  logic [PC_W-1:0]   branch_target_ex,
  input  logic              halt_req,
  input  logic              resume,
  output logic [PC_W-1:0]   pc_next,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    FLUSH    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam int FL_W = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [FL_W-1:0] FL_INIT = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [FL_W-1:0] FL_ONE  = FL_W'(1);

  state_t           state_q, state_d;
  logic [FL_W-1:0]  flush_left_q, flush_left_d;
  logic             stall_inc, flush_inc;
  logic             load_use;
  logic [PC_W-1:0]  pc_plus4;

  // x0 is hardwired zero, so a load to it never creates a dependency
  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
  assign pc_plus4 = pc_cur + PC_W'(4);
  assign state    = state_q;

  // State and squash-counter register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RST_HOLD;
      flush_left_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
    end
  end

  // Performance counters, saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  // Next-state and pipeline control decode; default is a frozen pipeline
  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    pc_next      = pc_cur;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    unique case (state_q)
      RST_HOLD: begin
        // First fetch after reset starts from address zero
        pc_next     = '0;
        pc_write    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (branch_taken_ex) begin
          // Redirect wins over a coincident load-use: the dependent instruction is wrong-path
          pc_next     = branch_target_ex;
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_left_d = FL_INIT;
            state_d      = FLUSH;
          end
        end else if (load_use) begin
          // One bubble suffices: the load moves on to MEM next cycle
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else if (halt_req) begin
          id_ex_flush = 1'b1;
          state_d     = HALTED;
        end else begin
          pc_next     = pc_plus4;
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      FLUSH: begin
        // Wrong-path instructions are squashed, so their hazards and branches are ignored
        pc_next      = pc_plus4;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        flush_left_d = flush_left_q - FL_ONE;
        if (flush_left_q <= FL_ONE)
          state_d = RUN;
      end
      HALTED: begin
        id_ex_flush = 1'b1;
        if (resume)
          state_d = RUN;
      end
      default: state_d = RST_HOLD;
    endcase
  end

endmodule

// File: tb/tb_pc_hazard_sequencer.sv
// tb/tb_pc_hazard_sequencer.sv - directed and randomized self-checking bench for pc_hazard_sequencer
module tb_pc_hazard_sequencer;

  localparam int PC_W = 64;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [63:0]     pc_cur, branch_target_ex, pc_next;
  logic            id_ex_mem_read, branch_taken_ex, halt_req, resume;
  logic [4:0]      id_ex_rd, if_id_rs1, if_id_rs2;
  logic            pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic [1:0]      state;
  logic [CW-1:0]   stall_count, flush_count;

  int vectors = 0;
  int miscompares = 0;

  // reference model: phase name, remaining squash cycles, event counts
  int m_phase;       // 0 reset-hold, 1 run, 2 squash, 3 halted
  int m_squash;
  int m_stalls;
  int m_redirects;
  int n_phase, n_squash, n_stalls, n_redirects;
  logic [63:0] e_pc;
  logic e_pw, e_iw, e_iff, e_ief;

  pc_hazard_sequencer #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .branch_taken_ex(branch_taken_ex), .branch_target_ex(branch_target_ex),
    .halt_req(halt_req), .resume(resume),
    .pc_next(pc_next), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_squash = 0; m_stalls = 0; m_redirects = 0;
  endtask

  // Derive expected outputs and next model values from the current inputs
  task automatic model_eval();
    logic hazard;
    hazard = id_ex_mem_read && (id_ex_rd != 0) &&
             ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    n_phase = m_phase; n_squash = m_squash;
    n_stalls = m_stalls; n_redirects = m_redirects;
    e_pc = pc_cur; e_pw = 0; e_iw = 0; e_iff = 0; e_ief = 1;
    if (m_phase == 0) begin
      e_pc = 64'd0; e_pw = 1; e_iff = 1; n_phase = 1;
    end else if (m_phase == 1) begin
      if (branch_taken_ex) begin
        e_pc = branch_target_ex; e_pw = 1; e_iw = 1; e_iff = 1;
        n_redirects = (m_redirects < CMAX) ? m_redirects + 1 : CMAX;
        if (FC > 1) begin n_phase = 2; n_squash = FC - 1; end
      end else if (hazard) begin
        n_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
      end else if (halt_req) begin
        n_phase = 3;
      end else begin
        e_pc = pc_cur + 64'd4; e_pw = 1; e_iw = 1; e_ief = 0;
      end
    end else if (m_phase == 2) begin
      e_pc = pc_cur + 64'd4; e_pw = 1; e_iw = 1; e_iff = 1;
      n_squash = m_squash - 1;
      if (n_squash == 0) n_phase = 1;
    end else begin
      if (resume) n_phase = 1;
    end
  endtask

  task automatic check_all();
    model_eval();
    chk("state", 64'(state), 64'(m_phase));
    chk("pc_next", pc_next, e_pc);
    chk("pc_write", 64'(pc_write), 64'(e_pw));
    chk("if_id_write", 64'(if_id_write), 64'(e_iw));
    chk("if_id_flush", 64'(if_id_flush), 64'(e_iff));
    chk("id_ex_flush", 64'(id_ex_flush), 64'(e_ief));
    chk("stall_count", 64'(stall_count), 64'(m_stalls));
    chk("flush_count", 64'(flush_count), 64'(m_redirects));
  endtask

  // One clock: check mid-cycle, then advance the model on the rising edge
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (reset) model_reset();
    else begin
      m_phase = n_phase; m_squash = n_squash;
      m_stalls = n_stalls; m_redirects = n_redirects;
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_ex_mem_read = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    branch_taken_ex = 0; branch_target_ex = 0; halt_req = 0; resume = 0;
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1; #1;
    model_reset();
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_stall"}, 64'(stall_count), 64'd0);
    chk({tag, "_flush"}, 64'(flush_count), 64'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1; pc_cur = 64'h40;
    model_reset();
    #12;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_stall", 64'(stall_count), 64'd0);
    chk("reset_flush", 64'(flush_count), 64'd0);
    @(posedge clk); #1;
    reset = 0;
    cycle();                                   // RST_HOLD
    cycle();                                   // RUN, pc+4

    // load-use on rs2, then the same with rd=x0
    id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs2 = 5; if_id_rs1 = 7;
    cycle();
    id_ex_rd = 0; if_id_rs2 = 0;
    cycle();
    idle_inputs();

    // taken branch, a second one during squash is ignored
    branch_taken_ex = 1; branch_target_ex = 64'h1000;
    cycle();
    branch_target_ex = 64'h2000;
    cycle();
    idle_inputs();
    cycle();

    // branch and load-use together
    branch_taken_ex = 1; branch_target_ex = 64'h3000;
    id_ex_mem_read = 1; id_ex_rd = 9; if_id_rs1 = 9;
    cycle();
    idle_inputs();
    cycle(); cycle();

    // halt for five cycles, resume, re-halt and reset while halted
    halt_req = 1;
    repeat (5) cycle();
    halt_req = 0; resume = 1;
    cycle();
    resume = 0;
    cycle();
    halt_req = 1;
    cycle(); cycle();
    async_reset_check("halt_reset");
    cycle();
    reset = 0; halt_req = 0;
    cycle();

    // PC wrap at the top of the address space
    pc_cur = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    pc_cur = 64'h80;

    // stall counter saturation
    id_ex_mem_read = 1; id_ex_rd = 3; if_id_rs1 = 3;
    repeat (20) cycle();
    idle_inputs();

    // redirect counter saturation with back-to-back branches
    branch_taken_ex = 1; branch_target_ex = 64'h500;
    repeat (40) cycle();
    idle_inputs();
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      id_ex_mem_read   = ($urandom_range(0, 2) == 0);
      id_ex_rd         = 5'($urandom_range(0, 3));
      if_id_rs1        = 5'($urandom_range(0, 3));
      if_id_rs2        = 5'($urandom_range(0, 3));
      branch_taken_ex  = ($urandom_range(0, 5) == 0);
      branch_target_ex = {32'($urandom), 32'($urandom)} & ~64'h3;
      halt_req         = ($urandom_range(0, 7) == 0);
      resume           = ($urandom_range(0, 3) == 0);
      pc_cur           = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                         : {32'($urandom), 32'($urandom)} & ~64'h3;
      if (reset) reset = 0;
      else if ($urandom_range(0, 39) == 0) async_reset_check("rand_reset");
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
